// File: rtl/passcode_controller.sv
// Four-digit keypad passcode controller: entry, check, timed unlock, code change
// and timed lockout after repeated mismatches. Clocked from a 1 kHz tick.
module passcode_controller #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 3000,
    parameter int unsigned LOCKOUT_CYCLES = 10000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic        clk1KHz,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        clear,
    input  logic        set_req,
    output logic        unlocked,
    output logic        locked_out,
    output logic        fail_pulse,
    output logic [2:0]  digit_count,
    output logic [15:0] entry,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_NEWCODE = 3'd4,
        S_LOCKOUT = 3'd5
    } state_e;

    localparam logic [15:0] UNLOCK_LOAD  = 16'(UNLOCK_CYCLES - 1);
    localparam logic [15:0] LOCKOUT_LOAD = 16'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]  FAIL_LIMIT   = 3'(MAX_FAIL);

    state_e      state_q, state_d;
    logic [15:0] code_q, code_d;
    logic [15:0] entry_q, entry_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  fail_q, fail_d;
    logic [15:0] shifted;

    assign shifted = {entry_q[11:0], key_code};

    always_ff @(posedge clk1KHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            code_q  <= DEFAULT_CODE;
            entry_q <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            entry_q <= entry_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        entry_d = entry_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE, S_ENTRY: begin
                // clear has priority: a key arriving with clear is dropped
                if (clear) begin
                    state_d = S_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    entry_d = shifted;
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd3) ? S_CHECK : S_ENTRY;
                end
            end
            S_CHECK: begin
                entry_d = '0;
                cnt_d   = '0;
                if (entry_q == code_q) begin
                    state_d = S_OPEN;
                    fail_d  = '0;
                    timer_d = UNLOCK_LOAD;
                end else if (fail_q + 3'd1 == FAIL_LIMIT) begin
                    state_d = S_LOCKOUT;
                    fail_d  = '0;
                    timer_d = LOCKOUT_LOAD;
                end else begin
                    state_d = S_IDLE;
                    fail_d  = fail_q + 3'd1;
                end
            end
            S_OPEN: begin
                if (clear) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (set_req) begin
                    state_d = S_NEWCODE;
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_NEWCODE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (key_valid) begin
                    if (cnt_q == 3'd3) begin
                        code_d  = shifted;
                        entry_d = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        entry_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                entry_d = '0;
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    assign unlocked    = (state_q == S_OPEN) || (state_q == S_NEWCODE);
    assign locked_out  = (state_q == S_LOCKOUT);
    assign fail_pulse  = (state_q == S_CHECK) && (entry_q != code_q);
    assign digit_count = cnt_q;
    assign entry       = entry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_passcode_controller.sv
// Directed bench for passcode_controller: a queue-based reference model is
// compared against every output each cycle, plus hand-computed spot checks.
module tb_passcode_controller;

    localparam int U  = 3000;
    localparam int L  = 10000;
    localparam int MF = 3;

    logic        clk1KHz = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        clear;
    logic        set_req;
    logic        unlocked;
    logic        locked_out;
    logic        fail_pulse;
    logic [2:0]  digit_count;
    logic [15:0] entry;
    logic [2:0]  state;

    passcode_controller #(
        .DEFAULT_CODE  (16'h1234),
        .UNLOCK_CYCLES (U),
        .LOCKOUT_CYCLES(L),
        .MAX_FAIL      (MF)
    ) dut (
        .clk1KHz    (clk1KHz),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .clear      (clear),
        .set_req    (set_req),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_pulse (fail_pulse),
        .digit_count(digit_count),
        .entry      (entry),
        .state      (state)
    );

    always #5 clk1KHz = ~clk1KHz;

    int checks = 0;
    int errors = 0;
    int fcount = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: mode number, digits held as a queue, dwell as cycles left
    int         m_state;
    logic [3:0] m_digs[$];
    logic [15:0] m_code;
    int         m_miss;
    int         m_dwell;

    function automatic logic [15:0] packd();
        logic [15:0] v = '0;
        foreach (m_digs[i]) v = (v << 4) | 16'(m_digs[i]);
        return v;
    endfunction

    initial begin : model
        forever begin
            @(posedge clk1KHz or negedge reset_n);
            if (!reset_n) begin
                m_state = 0;
                m_digs.delete();
                m_code  = 16'h1234;
                m_miss  = 0;
                m_dwell = 0;
            end else begin
                case (m_state)
                    0, 1, 4: begin
                        if (clear) begin
                            m_digs.delete();
                            m_state = 0;
                        end else if (key_valid) begin
                            m_digs.push_back(key_code);
                            if (m_digs.size() == 4) begin
                                if (m_state == 4) begin
                                    m_code = packd();
                                    m_digs.delete();
                                    m_state = 0;
                                end else begin
                                    m_state = 2;
                                end
                            end else if (m_state == 0) begin
                                m_state = 1;
                            end
                        end
                    end
                    2: begin
                        if (packd() == m_code) begin
                            m_miss  = 0;
                            m_state = 3;
                            m_dwell = U;
                        end else begin
                            m_miss++;
                            if (m_miss == MF) begin
                                m_miss  = 0;
                                m_state = 5;
                                m_dwell = L;
                            end else begin
                                m_state = 0;
                            end
                        end
                        m_digs.delete();
                    end
                    3: begin
                        if (clear) m_state = 0;
                        else if (set_req) begin
                            m_state = 4;
                            m_digs.delete();
                        end else begin
                            m_dwell--;
                            if (m_dwell == 0) m_state = 0;
                        end
                    end
                    5: begin
                        m_dwell--;
                        if (m_dwell == 0) m_state = 0;
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    initial begin : compare
        logic [31:0] g;
        logic [31:0] e;
        forever begin
            @(negedge clk1KHz);
            if (fail_pulse === 1'b1) fcount++;
            g = {7'b0, state, unlocked, locked_out, fail_pulse, digit_count, entry};
            e = {7'b0, 3'(m_state), (m_state == 3) || (m_state == 4), m_state == 5,
                 (m_state == 2) && (packd() != m_code), 3'(m_digs.size()), packd()};
            chk("cycle_outputs", g, e);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk1KHz);
            #2;
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic press4(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    endtask

    initial begin : stim
        int cnt;
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        clear     = 1'b0;
        set_req   = 1'b0;
        step(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_unlocked", 32'(unlocked), 0);
        chk("rst_locked_out", 32'(locked_out), 0);
        chk("rst_fail_pulse", 32'(fail_pulse), 0);
        chk("rst_digit_count", 32'(digit_count), 0);
        chk("rst_entry", 32'(entry), 0);
        reset_n = 1'b1;
        step(2);

        // correct default code opens for exactly U cycles
        press(4'd1); press(4'd2); press(4'd3);
        chk("entry_3keys", 32'(entry), 32'h0123);
        chk("count_3keys", 32'(digit_count), 3);
        press(4'd4);
        chk("check_state", 32'(state), 2);
        step(1);
        chk("open_state", 32'(state), 3);
        chk("unlocked_rise", 32'(unlocked), 1);
        cnt = 0;
        while (unlocked === 1'b1 && cnt < U + 100) begin
            cnt++;
            step(1);
        end
        chk("unlock_len", 32'(cnt), 32'(U));
        chk("state_after_open", 32'(state), 0);
        chk("no_fail_pulse", 32'(fcount), 0);

        // three misses lock out; inputs during lockout are ignored
        repeat (3) begin
            press4(16'h0000);
            step(1);
        end
        chk("fail_pulses_3", 32'(fcount), 3);
        chk("lockout_entered", 32'(locked_out), 1);
        cnt = 0;
        while (locked_out === 1'b1 && cnt < L + 100) begin
            if (cnt < 8) begin
                key_valid = 1'b1;
                key_code  = 4'(cnt % 4 + 1);
                clear     = cnt[0];
                set_req   = cnt[1];
            end else begin
                key_valid = 1'b0;
                clear     = 1'b0;
                set_req   = 1'b0;
            end
            cnt++;
            step(1);
        end
        key_valid = 1'b0; clear = 1'b0; set_req = 1'b0;
        chk("lockout_len", 32'(cnt), 32'(L));
        chk("state_after_lockout", 32'(state), 0);
        chk("count_after_lockout", 32'(digit_count), 0);

        // change code to 9876 from OPEN
        press4(16'h1234);
        step(1);
        chk("open_for_change", 32'(state), 3);
        set_req = 1'b1;
        step(1);
        set_req = 1'b0;
        chk("newcode_state", 32'(state), 4);
        chk("newcode_unlocked", 32'(unlocked), 1);
        press4(16'h9876);
        chk("newcode_done_state", 32'(state), 0);
        chk("newcode_done_count", 32'(digit_count), 0);
        press4(16'h1234);
        chk("old_code_mismatch", 32'(fail_pulse), 1);
        step(1);
        press4(16'h9876);
        step(1);
        chk("new_code_opens", 32'(state), 3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear_relocks", 32'(state), 0);

        // clear with a key discards it and keeps the miss count
        press4(16'h0000); step(1);
        press4(16'h0000); step(1);
        press(4'd1); press(4'd2);
        clear = 1'b1; key_valid = 1'b1; key_code = 4'd3;
        step(1);
        clear = 1'b0; key_valid = 1'b0;
        chk("abort_count", 32'(digit_count), 0);
        chk("abort_entry", 32'(entry), 0);
        chk("abort_state", 32'(state), 0);
        press4(16'h0000); step(1);
        chk("miss_count_kept", 32'(locked_out), 1);

        // asynchronous reset in LOCKOUT
        step(5);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_lockout", 32'(locked_out), 0);
        chk("async_rst_lockout_state", 32'(state), 0);
        @(posedge clk1KHz); #2;
        reset_n = 1'b1;
        step(1);

        // program 5555, then asynchronous reset in OPEN restores the default
        press4(16'h1234); step(1);
        set_req = 1'b1; step(1); set_req = 1'b0;
        press4(16'h5555);
        chk("prog_5555_idle", 32'(state), 0);
        press4(16'h5555); step(1);
        chk("open_5555", 32'(state), 3);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_open", 32'(unlocked), 0);
        chk("async_rst_open_state", 32'(state), 0);
        @(posedge clk1KHz); #2;
        reset_n = 1'b1;
        step(1);
        press4(16'h5555);
        chk("5555_lost", 32'(fail_pulse), 1);
        step(1);
        press4(16'h1234); step(1);
        chk("default_restored", 32'(state), 3);
        clear = 1'b1; step(1); clear = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
